// File: rtl/elastic_mem_arbiter_if.sv
// Request, memory and response channels shared between the two requesters,
// the arbiter and the memory model.
interface elastic_mem_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             V0, V1, S0, S1;
  logic [WIDTH-1:0] adr0, adr1, wd0, wd1;
  logic             we0, we1;
  logic             VMem, SMem, memread, memwrite;
  logic [WIDTH-1:0] memadr, memwd;
  logic             VRsp, SRsp;
  logic [WIDTH-1:0] rspdata;
  logic             VR0, VR1, SR0, SR1;
  logic [WIDTH-1:0] rdata0, rdata1;

  // Environment side: requesters, memory model and response consumers
  modport master (
    output V0, V1, adr0, adr1, we0, we1, wd0, wd1, SMem, VRsp, rspdata, SR0, SR1,
    input  S0, S1, VMem, memadr, memwd, memread, memwrite, SRsp, VR0, VR1,
           rdata0, rdata1
  );

  // Arbiter side
  modport slave (
    input  V0, V1, adr0, adr1, we0, we1, wd0, wd1, SMem, VRsp, rspdata, SR0, SR1,
    output S0, S1, VMem, memadr, memwd, memread, memwrite, SRsp, VR0, VR1,
           rdata0, rdata1
  );
endinterface

// File: rtl/elastic_mem_arbiter.sv
// Round-robin arbiter sharing one elastic memory port between instruction
// fetch (port 0) and load/store (port 1), with an in-order tag FIFO that
// steers each read response back to its issuer.
module elastic_mem_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PTRBITS = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  elastic_mem_arbiter_if.slave bus,
  output logic [PTRBITS:0]   outstanding,
  output logic               err
);

  typedef enum logic {ST_FREE, ST_LOCKED} lock_state_t;

  lock_state_t        state, state_nx;
  logic               gnt, gnt_nx;
  logic               last, last_nx;
  logic [DEPTH-1:0]   tags;
  logic [PTRBITS-1:0] wr_ptr, rd_ptr;
  logic [PTRBITS:0]   count, count_nx;
  logic               err_nx;

  logic               sel, v_sel, we_sel, full, empty, xfer, push, pop, head;
  logic [WIDTH-1:0]   adr_sel, wd_sel;

  // Grant selection, issue handshake and response routing
  always_comb begin
    sel      = ~last;
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    err_nx   = err;

    full  = (count == (PTRBITS+1)'(DEPTH));
    empty = (count == '0);

    if (state == ST_LOCKED)        sel = gnt;
    else if (bus.V0 && !bus.V1)    sel = 1'b0;
    else if (bus.V1 && !bus.V0)    sel = 1'b1;

    v_sel   = sel ? bus.V1   : bus.V0;
    we_sel  = sel ? bus.we1  : bus.we0;
    adr_sel = sel ? bus.adr1 : bus.adr0;
    wd_sel  = sel ? bus.wd1  : bus.wd0;

    bus.VMem     = v_sel & ~(~we_sel & full);
    bus.memadr   = adr_sel;
    bus.memwd    = wd_sel;
    bus.memread  = bus.VMem & ~we_sel;
    bus.memwrite = bus.VMem & we_sel;

    xfer   = bus.VMem & ~bus.SMem;
    bus.S0 = sel ? bus.V0 : (bus.V0 & ~xfer);
    bus.S1 = sel ? (bus.V1 & ~xfer) : bus.V1;

    // Grant is held across a memory stall and released on transfer
    if (bus.VMem && bus.SMem) begin
      state_nx = ST_LOCKED;
      gnt_nx   = sel;
    end else if (xfer) begin
      state_nx = ST_FREE;
      last_nx  = sel;
    end

    head       = tags[rd_ptr];
    bus.VR0    = ~empty & bus.VRsp & ~head;
    bus.VR1    = ~empty & bus.VRsp & head;
    bus.SRsp   = ~empty & bus.VRsp & (head ? bus.SR1 : bus.SR0);
    bus.rdata0 = bus.rspdata;
    bus.rdata1 = bus.rspdata;

    // A response with nothing outstanding is dropped and flagged
    if (empty && bus.VRsp) err_nx = 1'b1;

    push     = xfer & ~we_sel & ~full;
    pop      = ~empty & bus.VRsp & ~bus.SRsp;
    count_nx = count + (PTRBITS+1)'(push) - (PTRBITS+1)'(pop);
  end

  // State register, tag FIFO and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FREE;
      gnt    <= 1'b0;
      last   <= 1'b1;
      tags   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      count <= count_nx;
      err   <= err_nx;
      if (push) begin
        tags[wr_ptr] <= sel;
        wr_ptr       <= wr_ptr + PTRBITS'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTRBITS'(1);
    end
  end

  assign outstanding = count;

endmodule

// File: tb/tb_elastic_mem_arbiter.sv
// Directed bench for elastic_mem_arbiter: arbitration, stall lock, FIFO
// full blocking, response routing, empty-response error and mid-run reset.
module tb_elastic_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] outstanding;
  logic       err;
  int         passed = 0;
  int         total  = 0;

  elastic_mem_arbiter_if #(.WIDTH(8)) bus ();

  elastic_mem_arbiter #(.WIDTH(8), .DEPTH(2), .PTRBITS(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.V0 = 0; bus.V1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.adr0 = 8'h00; bus.adr1 = 8'h00; bus.wd0 = 8'h00; bus.wd1 = 8'h00;
    bus.SMem = 0; bus.VRsp = 0; bus.rspdata = 8'h00; bus.SR0 = 0; bus.SR1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); reset = 0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({bus.VMem, bus.S0, bus.S1, bus.SRsp} !== 4'b0000)
      $display("FAIL reset_req got %b exp 0000", {bus.VMem, bus.S0, bus.S1, bus.SRsp}); else passed++;
    total++; if ({bus.VR0, bus.VR1, bus.memread, bus.memwrite} !== 4'b0000)
      $display("FAIL reset_rsp got %b exp 0000", {bus.VR0, bus.VR1, bus.memread, bus.memwrite}); else passed++;
    total++; if (outstanding !== 2'd0) $display("FAIL reset_outst got %0d exp 0", outstanding); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.V0 = 1; bus.V1 = 1; bus.adr0 = 8'h10; bus.adr1 = 8'h20; #1;
    total++; if (bus.memadr !== 8'h10) $display("FAIL rr_adr0 got %h exp 10", bus.memadr); else passed++;
    total++; if ({bus.S0, bus.S1, bus.memread} !== 3'b011)
      $display("FAIL rr_stop0 got %b exp 011", {bus.S0, bus.S1, bus.memread}); else passed++;
    tick();
    total++; if (bus.memadr !== 8'h20) $display("FAIL rr_adr1 got %h exp 20", bus.memadr); else passed++;
    total++; if (bus.S1 !== 1'b0) $display("FAIL rr_s1 got %b exp 0", bus.S1); else passed++;
    tick();
    bus.V0 = 0; bus.V1 = 0; #1;
    total++; if (outstanding !== 2'd2) $display("FAIL rr_outst got %0d exp 2", outstanding); else passed++;
  endtask

  task automatic test_lock();
    do_reset();
    bus.V0 = 1; bus.V1 = 1; bus.adr0 = 8'h10; bus.adr1 = 8'h20; bus.SMem = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({bus.memadr, bus.S0, bus.S1} !== {8'h10, 2'b11})
        $display("FAIL lock_stall%0d got %h/%b%b exp 10/11", i, bus.memadr, bus.S0, bus.S1); else passed++;
      tick();
    end
    bus.SMem = 0; #1;
    total++; if ({bus.memadr, bus.S0} !== {8'h10, 1'b0})
      $display("FAIL lock_rel0 got %h/%b exp 10/0", bus.memadr, bus.S0); else passed++;
    tick(); bus.V0 = 0; #1;
    total++; if ({bus.memadr, bus.S1} !== {8'h20, 1'b0})
      $display("FAIL lock_rel1 got %h/%b exp 20/0", bus.memadr, bus.S1); else passed++;
    tick(); bus.V1 = 0; #1;
    total++; if (outstanding !== 2'd2) $display("FAIL lock_outst got %0d exp 2", outstanding); else passed++;
  endtask

  task automatic test_lock_hold();
    do_reset();
    bus.V1 = 1; bus.adr1 = 8'h20; bus.adr0 = 8'h10; bus.SMem = 1;
    tick();
    bus.V0 = 1; #1;
    total++; if ({bus.memadr, bus.S0} !== {8'h20, 1'b1})
      $display("FAIL hold_gnt got %h/%b exp 20/1", bus.memadr, bus.S0); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    bus.V0 = 1; bus.adr0 = 8'h01; tick();
    bus.adr0 = 8'h02; tick();
    bus.adr0 = 8'h03; #1;
    total++; if ({bus.VMem, bus.S0} !== 2'b01)
      $display("FAIL full_block got %b exp 01", {bus.VMem, bus.S0}); else passed++;
    total++; if (outstanding !== 2'd2) $display("FAIL full_outst got %0d exp 2", outstanding); else passed++;
    bus.V1 = 1; bus.we1 = 1; bus.adr1 = 8'h30; bus.wd1 = 8'h5A; #1;
    total++; if ({bus.VMem, bus.memwrite, bus.memread, bus.S1} !== 4'b1100)
      $display("FAIL full_wr_ctl got %b exp 1100", {bus.VMem, bus.memwrite, bus.memread, bus.S1}); else passed++;
    total++; if ({bus.memadr, bus.memwd} !== 16'h305A)
      $display("FAIL full_wr_data got %h exp 305a", {bus.memadr, bus.memwd}); else passed++;
    tick(); bus.V1 = 0; bus.V0 = 0; #1;
    total++; if (outstanding !== 2'd2) $display("FAIL full_wr_outst got %0d exp 2", outstanding); else passed++;
  endtask

  task automatic test_response();
    do_reset();
    bus.V0 = 1; bus.adr0 = 8'h10; tick();
    bus.V0 = 0; bus.V1 = 1; bus.adr1 = 8'h20; tick();
    bus.V1 = 0; bus.VRsp = 1; bus.rspdata = 8'hAA; #1;
    total++; if ({bus.VR0, bus.VR1, bus.SRsp, bus.rdata0} !== {3'b100, 8'hAA})
      $display("FAIL rsp_first got %b%b%b/%h exp 100/aa", bus.VR0, bus.VR1, bus.SRsp, bus.rdata0); else passed++;
    tick();
    bus.rspdata = 8'hBB; bus.SR1 = 1; #1;
    total++; if ({bus.VR0, bus.VR1, bus.SRsp, bus.rdata1} !== {3'b011, 8'hBB})
      $display("FAIL rsp_second got %b%b%b/%h exp 011/bb", bus.VR0, bus.VR1, bus.SRsp, bus.rdata1); else passed++;
    total++; if (outstanding !== 2'd1) $display("FAIL rsp_outst1 got %0d exp 1", outstanding); else passed++;
    tick(); tick();
    total++; if (outstanding !== 2'd1) $display("FAIL rsp_stall_outst got %0d exp 1", outstanding); else passed++;
    bus.SR1 = 0; #1;
    total++; if ({bus.VR1, bus.SRsp} !== 2'b10)
      $display("FAIL rsp_release got %b exp 10", {bus.VR1, bus.SRsp}); else passed++;
    tick(); bus.VRsp = 0; #1;
    total++; if (outstanding !== 2'd0) $display("FAIL rsp_drain got %0d exp 0", outstanding); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rsp_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_empty_rsp();
    do_reset();
    bus.VRsp = 1; bus.rspdata = 8'h77; #1;
    total++; if ({bus.VR0, bus.VR1, bus.SRsp} !== 3'b000)
      $display("FAIL empty_route got %b exp 000", {bus.VR0, bus.VR1, bus.SRsp}); else passed++;
    tick(); bus.VRsp = 0; #1;
    total++; if (err !== 1'b1) $display("FAIL empty_err got %b exp 1", err); else passed++;
    tick(); tick();
    total++; if (err !== 1'b1) $display("FAIL empty_sticky got %b exp 1", err); else passed++;
    total++; if (outstanding !== 2'd0) $display("FAIL empty_outst got %0d exp 0", outstanding); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.V0 = 1; bus.adr0 = 8'h10; tick();
    bus.V0 = 0; bus.V1 = 1; bus.adr1 = 8'h20; bus.SMem = 1; tick();
    reset = 1; tick(); reset = 0;
    bus.SMem = 0; bus.V0 = 1; #1;
    total++; if ({outstanding, err} !== 3'b000)
      $display("FAIL mid_state got %0d/%b exp 0/0", outstanding, err); else passed++;
    total++; if ({bus.memadr, bus.S0, bus.S1} !== {8'h10, 2'b01})
      $display("FAIL mid_gnt got %h/%b%b exp 10/01", bus.memadr, bus.S0, bus.S1); else passed++;
    tick(); bus.V0 = 0; bus.V1 = 0; #1;
    total++; if (outstanding !== 2'd1) $display("FAIL mid_outst got %0d exp 1", outstanding); else passed++;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_hold();
    test_full();
    test_response();
    test_empty_rsp();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
